// File: rtl/game_pkg.sv
// game_pkg: global game_state encodings and the lives/level FSM state type.
package game_pkg;
   localparam logic [1:0] GS_START = 2'b00;
   localparam logic [1:0] GS_PLAY  = 2'b01;
   localparam logic [1:0] GS_OVER  = 2'b10;
   typedef enum logic [1:0] {IDLE, SERVE, RUN, DONE} state_t;
endpackage

// File: rtl/edge_pulse.sv
// edge_pulse: rising-edge detector; previous value resets high so a level held across reset is not an edge.
module edge_pulse (
   input  logic clk_i,
   input  logic rst_i,
   input  logic in_i,
   output logic rise_o
);
   logic prev_q;
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) prev_q <= 1'b1;
      else       prev_q <= in_i;
   assign rise_o = in_i & ~prev_q;
endmodule

// File: rtl/lives_level_ctrl.sv
// lives_level_ctrl: tracks lives and level, paces serves, and requests global game-state transitions.
module lives_level_ctrl import game_pkg::*; #(
   parameter int LIVES_INIT = 3,
   parameter int LEVEL_MAX  = 7,
   parameter int SERVE_DLY  = 50_000_000
) (
   input  logic       CLK_50M,
   input  logic       RST,
   input  logic       key_start,
   input  logic       key_reset,
   input  logic [1:0] game_state,
   input  logic       ball_lost,
   input  logic       level_clear,
   output logic       game_start,
   output logic       game_over,
   output logic       game_reset,
   output logic       serve_en,
   output logic [1:0] lives,
   output logic [2:0] level,
   output logic       win
);
   localparam int CW = $clog2(SERVE_DLY + 1);
   state_t state_q, state_d;
   logic [1:0] lives_q, lives_d;
   logic [2:0] level_q, level_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic win_q, win_d, start_q, start_d, over_q, over_d, reset_q, reset_d, serve_q, serve_d;
   logic start_rise, reset_rise;
   edge_pulse u_start (.clk_i(CLK_50M), .rst_i(RST), .in_i(key_start), .rise_o(start_rise));
   edge_pulse u_reset (.clk_i(CLK_50M), .rst_i(RST), .in_i(key_reset), .rise_o(reset_rise));
   always_comb begin
      state_d = state_q;
      lives_d = lives_q;
      level_d = level_q;
      win_d   = win_q;
      cnt_d   = cnt_q;
      start_d = 1'b0;
      over_d  = 1'b0;
      reset_d = 1'b0;
      if (game_state == 2'b11 || (game_state == GS_START && state_q != IDLE)) state_d = IDLE;
      else begin
         case (state_q)
            IDLE:
               if (start_rise && game_state == GS_START) begin
                  start_d = 1'b1;
                  state_d = SERVE;
                  cnt_d   = CW'(SERVE_DLY - 1);
               end
            SERVE:
               if (cnt_q == '0) state_d = RUN;
               else             cnt_d   = cnt_q - CW'(1);
            RUN:
               // level_clear takes priority over a coincident ball_lost
               if (level_clear) begin
                  if (level_q == 3'(LEVEL_MAX)) begin
                     win_d   = 1'b1;
                     over_d  = 1'b1;
                     state_d = DONE;
                  end else begin
                     level_d = level_q + 3'd1;
                     state_d = SERVE;
                     cnt_d   = CW'(SERVE_DLY - 1);
                  end
               end else if (ball_lost) begin
                  if (lives_q > 2'd1) begin
                     lives_d = lives_q - 2'd1;
                     state_d = SERVE;
                     cnt_d   = CW'(SERVE_DLY - 1);
                  end else begin
                     lives_d = 2'd0;
                     over_d  = 1'b1;
                     state_d = DONE;
                  end
               end
            default:
               if (reset_rise && game_state == GS_OVER) begin
                  reset_d = 1'b1;
                  state_d = IDLE;
               end
         endcase
      end
      // every path into IDLE reloads a fresh game
      if (state_d == IDLE) begin
         lives_d = 2'(LIVES_INIT);
         level_d = 3'd0;
         win_d   = 1'b0;
         cnt_d   = '0;
      end
      serve_d = state_d == RUN;
   end
   always_ff @(posedge CLK_50M or posedge RST)
      if (RST) begin
         state_q <= IDLE;
         lives_q <= 2'(LIVES_INIT);
         level_q <= 3'd0;
         win_q   <= 1'b0;
         cnt_q   <= '0;
         start_q <= 1'b0;
         over_q  <= 1'b0;
         reset_q <= 1'b0;
         serve_q <= 1'b0;
      end else begin
         state_q <= state_d;
         lives_q <= lives_d;
         level_q <= level_d;
         win_q   <= win_d;
         cnt_q   <= cnt_d;
         start_q <= start_d;
         over_q  <= over_d;
         reset_q <= reset_d;
         serve_q <= serve_d;
      end
   assign game_start = start_q;
   assign game_over  = over_q;
   assign game_reset = reset_q;
   assign serve_en   = serve_q;
   assign lives      = lives_q;
   assign level      = level_q;
   assign win        = win_q;
endmodule

// File: tb/tb_lives_level_ctrl.sv
// tb_lives_level_ctrl: table-driven game sequence plus directed level-clear, priority, abort and reset sequences.
module tb_lives_level_ctrl;
   import game_pkg::*;
   logic CLK_50M = 1'b0, RST = 1'b1;
   logic key_start = 1'b0, key_reset = 1'b0, ball_lost = 1'b0, level_clear = 1'b0;
   logic [1:0] game_state = GS_START;
   logic game_start, game_over, game_reset, serve_en, win;
   logic [1:0] lives;
   logic [2:0] level;
   int total = 0, passed = 0;
   typedef struct {
      logic ks, kr;
      logic [1:0] gs;
      logic bl, lc;
      logic [9:0] exp;
   } vec_t;
   vec_t vecs[$];
   lives_level_ctrl #(.LIVES_INIT(3), .LEVEL_MAX(7), .SERVE_DLY(4)) dut (
      .CLK_50M(CLK_50M), .RST(RST), .key_start(key_start), .key_reset(key_reset),
      .game_state(game_state), .ball_lost(ball_lost), .level_clear(level_clear),
      .game_start(game_start), .game_over(game_over), .game_reset(game_reset),
      .serve_en(serve_en), .lives(lives), .level(level), .win(win)
   );
   always #5 CLK_50M = ~CLK_50M;
   function automatic logic [9:0] pk(input logic s, o, r, se, input logic [1:0] lv, input logic [2:0] lev, input logic w);
      return {s, o, r, se, lv, lev, w};
   endfunction
   function automatic logic [9:0] outs();
      return {game_start, game_over, game_reset, serve_en, lives, level, win};
   endfunction
   task automatic chk(input string name, input logic [9:0] got, input logic [9:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got st/ov/rs/se/lives/level/win=%b required %b", name, got, exp);
   endtask
   task automatic step(input logic ks, kr, input logic [1:0] gs, input logic bl, lc);
      @(negedge CLK_50M);
      key_start = ks; key_reset = kr; game_state = gs; ball_lost = bl; level_clear = lc;
      @(posedge CLK_50M);
      #1;
   endtask
   task automatic add(input logic ks, kr, input logic [1:0] gs, input logic bl, lc, input logic [9:0] exp);
      vecs.push_back('{ks, kr, gs, bl, lc, exp});
   endtask
   task automatic serve_wait(input logic ks);
      repeat (4) step(ks, 1'b0, GS_PLAY, 1'b0, 1'b0);
   endtask
   initial begin
      add(0,0,GS_START,0,0, pk(0,0,0,0,3,0,0));
      add(1,0,GS_START,0,0, pk(1,0,0,0,3,0,0));
      add(1,0,GS_PLAY ,0,0, pk(0,0,0,0,3,0,0));
      add(0,0,GS_PLAY ,0,0, pk(0,0,0,0,3,0,0));
      add(0,0,GS_PLAY ,0,0, pk(0,0,0,0,3,0,0));
      add(0,0,GS_PLAY ,0,0, pk(0,0,0,1,3,0,0));
      add(0,0,GS_PLAY ,1,0, pk(0,0,0,0,2,0,0));
      add(0,0,GS_PLAY ,0,1, pk(0,0,0,0,2,0,0));
      add(0,0,GS_PLAY ,1,0, pk(0,0,0,0,2,0,0));
      add(0,0,GS_PLAY ,0,0, pk(0,0,0,0,2,0,0));
      add(0,0,GS_PLAY ,0,0, pk(0,0,0,1,2,0,0));
      add(0,0,GS_PLAY ,1,0, pk(0,0,0,0,1,0,0));
      add(0,0,GS_PLAY ,0,0, pk(0,0,0,0,1,0,0));
      add(0,0,GS_PLAY ,0,0, pk(0,0,0,0,1,0,0));
      add(0,0,GS_PLAY ,0,0, pk(0,0,0,0,1,0,0));
      add(0,0,GS_PLAY ,0,0, pk(0,0,0,1,1,0,0));
      add(0,0,GS_PLAY ,1,0, pk(0,1,0,0,0,0,0));
      add(0,0,GS_PLAY ,1,1, pk(0,0,0,0,0,0,0));
      add(0,1,GS_OVER ,0,0, pk(0,0,1,0,3,0,0));
      add(0,1,GS_START,0,0, pk(0,0,0,0,3,0,0));
      repeat (2) @(posedge CLK_50M);
      #1 chk("reset_state", outs(), pk(0,0,0,0,3,0,0));
      @(negedge CLK_50M) RST = 1'b0;
      foreach (vecs[i]) begin
         step(vecs[i].ks, vecs[i].kr, vecs[i].gs, vecs[i].bl, vecs[i].lc);
         chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
      end
      // eight level clears to a win
      step(1, 0, GS_START, 0, 0);
      chk("lc_start", outs(), pk(1,0,0,0,3,0,0));
      serve_wait(0);
      chk("lc_run0", outs(), pk(0,0,0,1,3,0,0));
      for (int i = 0; i < 8; i++) begin
         step(0, 0, GS_PLAY, 0, 1);
         if (i < 7) begin
            chk($sformatf("lc_clear%0d", i), outs(), pk(0,0,0,0,3,3'(i+1),0));
            serve_wait(0);
            chk($sformatf("lc_serve%0d", i), outs(), pk(0,0,0,1,3,3'(i+1),0));
         end else chk("lc_win", outs(), pk(0,1,0,0,3,7,1));
      end
      step(0, 0, GS_OVER, 1, 1);
      chk("lc_hold", outs(), pk(0,0,0,0,3,7,1));
      step(0, 1, GS_OVER, 0, 0);
      chk("lc_reset", outs(), pk(0,0,1,0,3,0,0));
      step(0, 0, GS_START, 0, 0);
      // simultaneous ball_lost and level_clear at lives=1 level=2
      step(1, 0, GS_START, 0, 0);
      serve_wait(0);
      repeat (2) begin step(0, 0, GS_PLAY, 1, 0); serve_wait(0); end
      repeat (2) begin step(0, 0, GS_PLAY, 0, 1); serve_wait(0); end
      chk("pri_setup", outs(), pk(0,0,0,1,1,2,0));
      step(0, 0, GS_PLAY, 1, 1);
      chk("pri_both", outs(), pk(0,0,0,0,1,3,0));
      step(0, 0, GS_START, 0, 0);
      chk("abort_start", outs(), pk(0,0,0,0,3,0,0));
      step(1, 0, GS_START, 0, 0);
      chk("illegal_start", outs(), pk(1,0,0,0,3,0,0));
      step(0, 0, 2'b11, 0, 0);
      serve_wait(0);
      chk("illegal_idle", outs(), pk(0,0,0,0,3,0,0));
      // async reset mid-RUN with key_start held
      step(0, 0, GS_START, 0, 0);
      step(1, 0, GS_START, 0, 0);
      serve_wait(1);
      step(1, 0, GS_PLAY, 1, 0);
      serve_wait(1);
      chk("rst_prerun", outs(), pk(0,0,0,1,2,0,0));
      @(negedge CLK_50M) RST = 1'b1;
      #1 chk("rst_async", outs(), pk(0,0,0,0,3,0,0));
      @(negedge CLK_50M) begin RST = 1'b0; game_state = GS_START; end
      for (int i = 0; i < 3; i++) begin
         step(1, 0, GS_START, 0, 0);
         chk($sformatf("rst_release%0d", i), outs(), pk(0,0,0,0,3,0,0));
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/lives_level_ctrl.md
LIVES_LEVEL_CTRL -- requirements
Module: lives_level_ctrl

Interface
REQ-001 SHALL have parameter LIVES_INIT, default 3, lives loaded at game start (1..3).
REQ-002 SHALL have parameter LEVEL_MAX, default 7, last level index; clearing it wins the game.
REQ-003 SHALL have parameter SERVE_DLY, default 50_000_000, number of serve-pause cycles before play resumes (>=1).
REQ-004 SHALL have port CLK_50M  in  1  sole clock, all logic on its rising edge.
REQ-005 SHALL have port RST  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port key_start  in  1  debounced start button, level.
REQ-007 SHALL have port key_reset  in  1  debounced reset button, level.
REQ-008 SHALL have port game_state  in  2  global state: 00 START, 01 PLAY, 10 OVER, 11 illegal.
REQ-009 SHALL have port ball_lost  in  1  one-cycle pulse, ball fell past paddle.
REQ-010 SHALL have port level_clear  in  1  one-cycle pulse, last block of level destroyed.
REQ-011 SHALL have port game_start  out  1  one-cycle request START->PLAY.
REQ-012 SHALL have port game_over  out  1  one-cycle request PLAY->OVER.
REQ-013 SHALL have port game_reset  out  1  one-cycle request OVER->START.
REQ-014 SHALL have port serve_en  out  1  high = ball motion allowed.
REQ-015 SHALL have port lives  out  2  remaining lives.
REQ-016 SHALL have port level  out  3  current level index.
REQ-017 SHALL have port win  out  1  high = game ended by clearing LEVEL_MAX.

Function
REQ-018 SHALL implement FSM states IDLE, SERVE, RUN, DONE.
REQ-019 SHALL detect key_start/key_reset rising edges from a registered previous value; a key high across reset release SHALL NOT produce an edge.
REQ-020 IDLE: lives=LIVES_INIT, level=0, win=0, serve_en=0; on key_start edge with game_state==START, SHALL pulse game_start for 1 cycle and enter SERVE.
REQ-021 SERVE: serve_en=0; counter loads SERVE_DLY-1 on entry, decrements each cycle; at 0 SHALL enter RUN the next cycle (exactly SERVE_DLY cycles in SERVE).
REQ-022 RUN: serve_en=1; ball_lost with lives>1 SHALL decrement lives and enter SERVE.
REQ-023 RUN: ball_lost with lives==1 SHALL set lives=0, pulse game_over for 1 cycle, enter DONE.
REQ-024 RUN: level_clear with level<LEVEL_MAX SHALL increment level and enter SERVE; lives unchanged.
REQ-025 RUN: level_clear with level==LEVEL_MAX SHALL set win=1, pulse game_over, enter DONE.
REQ-026 Simultaneous ball_lost and level_clear in RUN: level_clear SHALL win; ball_lost ignored.
REQ-027 ball_lost/level_clear outside RUN SHALL be ignored.
REQ-028 DONE: serve_en=0, lives/level/win held; on key_reset edge with game_state==OVER, SHALL pulse game_reset and enter IDLE.
REQ-029 If game_state reads START while FSM is not IDLE, or reads 11, SHALL enter IDLE next cycle with no pulses.
REQ-030 At most one of game_start/game_over/game_reset SHALL be high in any cycle; all outputs registered.

Reset
REQ-031 RST high SHALL force asynchronously: FSM=IDLE, lives=LIVES_INIT, level=0, win=0, serve_en=0, all pulses 0, counter 0, key-previous registers 1.
REQ-032 Reset asserted mid-SERVE or mid-RUN SHALL abandon the game; no pulse SHALL be emitted on release.

Structure
REQ-033 Shared package game_pkg SHALL hold the game_state encodings (START/PLAY/OVER) and the FSM state type.
REQ-034 Rising-edge detection SHALL be sub-module edge_pulse, instantiated once per key.

Verification (SERVE_DLY=4, LIVES_INIT=3, LEVEL_MAX=7)
REQ-035 key_start rise, game_state=START -> game_start high 1 cycle, serve_en rises exactly 4 cycles after SERVE entry.
REQ-036 Three ball_lost pulses in RUN -> lives 3->2->1->0, SERVE between, game_over 1 cycle on third, win=0.
REQ-037 Eight level_clear pulses in RUN -> level 0..7, eighth gives game_over and win=1, lives stay 3.
REQ-038 ball_lost and level_clear same cycle at lives=1, level=2 -> level=3, lives=1, no game_over.
REQ-039 In DONE, key_reset rise with game_state=OVER -> game_reset 1 cycle, lives=3, level=0, win=0.
REQ-040 RST pulsed mid-RUN with key_start held -> all outputs at reset values, no game_start after release.
